// File: rtl/seq_trig_pkg.sv
// Shared defaults and state encoding for the multi-stage pattern sequence trigger.
package seq_trig_pkg;

    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_TMO_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/masked_match.sv
// Combinational masked equality: hit when every bit selected by the mask agrees.
module masked_match #(
    parameter int unsigned DATA_W = 128
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] pattern_i,
    input  logic [DATA_W-1:0] mask_i,
    output logic              hit_o
);

    assign hit_o = ((data_i ^ pattern_i) & mask_i) == '0;

endmodule

// File: rtl/pattern_seq_trigger.sv
// Sequence trigger: fires once DEPTH configured masked words arrive in order,
// with an optional inter-stage timeout that drops partial progress.
module pattern_seq_trigger
    import seq_trig_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TMO_W  = DEF_TMO_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
    input  logic [DATA_W-1:0]          cfg_pattern,
    input  logic [DATA_W-1:0]          cfg_mask,
    input  logic [TMO_W-1:0]           cfg_tmo,
    input  logic                       arm,
    input  logic                       clear,
    output logic                       trig,
    output logic [$clog2(DEPTH+1)-1:0] stage,
    output logic                       armed
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned STG_W = $clog2(DEPTH + 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(DEPTH - 1);
    localparam logic [STG_W-1:0] STG_DONE = STG_W'(DEPTH);

    seq_state_e state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              trig_q, trig_d;
    logic              armed_q, armed_d;

    logic [DATA_W-1:0] pattern_q [DEPTH];
    logic [DATA_W-1:0] mask_q    [DEPTH];
    logic [TMO_W-1:0]  tmo_q;

    logic [IDX_W-1:0]  sel_idx;
    logic              hit_stage;
    logic              hit_first;
    logic              tmo_hit;

    // Configuration is only writable while idle so a running sequence sees stable patterns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pattern_q[k] <= '0;
                mask_q[k]    <= '1;
            end
            tmo_q <= '0;
        end else if (cfg_we && (state_q == S_IDLE) && (32'(cfg_idx) < DEPTH)) begin
            pattern_q[cfg_idx] <= cfg_pattern;
            mask_q[cfg_idx]    <= cfg_mask;
            tmo_q              <= cfg_tmo;
        end
    end

    assign sel_idx = stage_q[IDX_W-1:0];

    masked_match #(.DATA_W(DATA_W)) u_match_stage (
        .data_i    (in_data),
        .pattern_i (pattern_q[sel_idx]),
        .mask_i    (mask_q[sel_idx]),
        .hit_o     (hit_stage)
    );

    masked_match #(.DATA_W(DATA_W)) u_match_first (
        .data_i    (in_data),
        .pattern_i (pattern_q[0]),
        .mask_i    (mask_q[0]),
        .hit_o     (hit_first)
    );

    // Timeout fires on the clock that would bring the counter up to tmo_q.
    assign tmo_hit = (stage_q != '0) && (tmo_q != '0) && (cnt_q == tmo_q - TMO_W'(1));

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        if (clear) begin
            state_d = S_IDLE;
            stage_d = '0;
            cnt_d   = '0;
            trig_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                        stage_d = '0;
                        cnt_d   = '0;
                    end
                end
                S_ARMED: begin
                    if (in_valid && hit_stage) begin
                        cnt_d = '0;
                        if (stage_q == STG_LAST) begin
                            state_d = S_FIRED;
                            stage_d = STG_DONE;
                            trig_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + STG_W'(1);
                        end
                    end else if (tmo_hit) begin
                        stage_d = '0;
                        cnt_d   = '0;
                    end else if (in_valid) begin
                        stage_d = hit_first ? STG_W'(1) : '0;
                        cnt_d   = '0;
                    end else if (stage_q != '0) begin
                        cnt_d = cnt_q + TMO_W'(1);
                    end
                end
                S_FIRED: begin
                end
                default: begin
                    state_d = S_IDLE;
                    stage_d = '0;
                    cnt_d   = '0;
                    trig_d  = 1'b0;
                end
            endcase
        end
        armed_d = (state_d == S_ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            armed_q <= armed_d;
        end
    end

    assign trig  = trig_q;
    assign stage = stage_q;
    assign armed = armed_q;

endmodule

// File: tb/tb_pattern_seq_trigger.sv
// Directed vectors for the sequence trigger: main sequencing table plus timeout, mask, clear and reset corners.
module tb_pattern_seq_trigger;

    localparam logic [127:0] PA   = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [127:0] PB   = 128'h3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C;
    localparam logic [127:0] PX   = 128'h5;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] W34  = {{120{1'b1}}, 8'h34};
    localparam logic [127:0] W35  = {{120{1'b1}}, 8'h35};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         cfg_we;
    logic [1:0]   cfg_idx;
    logic [127:0] cfg_pattern;
    logic [127:0] cfg_mask;
    logic [15:0]  cfg_tmo;
    logic         arm;
    logic         clear;
    logic         trig;
    logic [2:0]   stage;
    logic         armed;

    int total = 0;
    int bad   = 0;

    pattern_seq_trigger #(.DATA_W(128), .DEPTH(4), .TMO_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_tmo     (cfg_tmo),
        .arm         (arm),
        .clear       (clear),
        .trig        (trig),
        .stage       (stage),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         clr;
        logic         arm;
        logic         vld;
        logic [127:0] data;
        logic         trig;
        logic [2:0]   stg;
        logic         armd;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic c, logic a, logic v, logic [127:0] d,
                                logic t, logic [2:0] s, logic ad);
        vec_t r;
        r.clr = c; r.arm = a; r.vld = v; r.data = d;
        r.trig = t; r.stg = s; r.armd = ad;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic t, input logic [2:0] s, input logic a);
        check({tag, "_trig"},  32'(trig),  32'(t));
        check({tag, "_stage"}, 32'(stage), 32'(s));
        check({tag, "_armed"}, 32'(armed), 32'(a));
    endtask

    task automatic cfg_write(input int idx, input logic [127:0] p, input logic [127:0] m,
                             input logic [15:0] t);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_pattern = p; cfg_mask = m; cfg_tmo = t;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic feed(input logic [127:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_pattern = '0; cfg_mask = '0; cfg_tmo = '0; arm = 1'b0; clear = 1'b0;
        step(); step();
        expect_out("reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        cfg_write(0, PA, ONES, 16'd0);
        cfg_write(1, PB, ONES, 16'd0);
        cfg_write(2, '0, ONES, 16'd0);
        cfg_write(3, 128'h1, ONES, 16'd0);

        //               clr   arm   vld   data  trig  stg   armed
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, PA,    1'b0, 3'd0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, '0,    1'b0, 3'd0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, PA,    1'b0, 3'd1, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, PB,    1'b0, 3'd2, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, '0,    1'b0, 3'd3, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 128'h1, 1'b1, 3'd4, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, PA,    1'b1, 3'd4, 1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, '0,    1'b0, 3'd0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, '0,    1'b0, 3'd0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, PA,    1'b0, 3'd1, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, PB,    1'b0, 3'd1, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, PB,    1'b0, 3'd2, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, PX,    1'b0, 3'd0, 1'b1);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, PA,    1'b0, 3'd1, 1'b1);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, PB,    1'b0, 3'd2, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, PA,    1'b0, 3'd1, 1'b1);
        tbl[16] = mk(1'b0, 1'b0, 1'b1, PB,    1'b0, 3'd2, 1'b1);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, '0,    1'b0, 3'd3, 1'b1);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 128'h1, 1'b1, 3'd4, 1'b0);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, '0,    1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            clear = tbl[i].clr; arm = tbl[i].arm; in_valid = tbl[i].vld; in_data = tbl[i].data;
            step();
            expect_out($sformatf("vec%0d", i), tbl[i].trig, tbl[i].stg, tbl[i].armd);
        end
        clear = 1'b0; arm = 1'b0; in_valid = 1'b0; in_data = '0;

        // Inter-stage timeout of 3 clocks
        cfg_write(0, PA, ONES, 16'd3);
        pulse_arm();
        feed(PA);  check("tmo_start", 32'(stage), 32'd1);
        step();    check("tmo_idle1", 32'(stage), 32'd1);
        step();    check("tmo_idle2", 32'(stage), 32'd1);
        step();    check("tmo_expire", 32'(stage), 32'd0);
        feed(PB);  check("tmo_no_adv", 32'(stage), 32'd0);
        feed(PA);  check("tmo_restart", 32'(stage), 32'd1);
        step(); step();
        feed(PB);  check("tmo_match_wins", 32'(stage), 32'd2);
        step(); step();
        feed(PA);  check("tmo_beats_valid", 32'(stage), 32'd0);
        pulse_clear();
        cfg_write(0, PA, ONES, 16'd0);

        // Partial mask on stage 2
        cfg_write(2, 128'h34, 128'hFF, 16'd0);
        pulse_arm();
        feed(PA); feed(PB);
        feed(W34);     check("mask_adv", 32'(stage), 32'd3);
        feed(128'h1);  expect_out("mask_fire", 1'b1, 3'd4, 1'b0);
        pulse_clear();
        pulse_arm();
        feed(PA); feed(PB);
        feed(W35);     check("mask_miss", 32'(stage), 32'd0);
        pulse_clear();

        // Clear coinciding with the final-stage match
        pulse_arm();
        feed(PA); feed(PB); feed(W34);
        check("clrfin_pre", 32'(stage), 32'd3);
        clear = 1'b1; in_valid = 1'b1; in_data = 128'h1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        expect_out("clr_beats_fire", 1'b0, 3'd0, 1'b0);
        feed(128'h1);
        expect_out("clr_idle_hold", 1'b0, 3'd0, 1'b0);

        // Config writes while armed are dropped
        pulse_arm();
        cfg_write(0, PX, ONES, 16'd0);
        check("cfg_armed_state", 32'(armed), 32'd1);
        feed(PA);  check("cfg_armed_kept", 32'(stage), 32'd1);
        pulse_clear();

        // Reset out of FIRED restores default patterns and full masks
        pulse_arm();
        feed(PA); feed(PB); feed(W34); feed(128'h1);
        expect_out("pre_rst_fired", 1'b1, 3'd4, 1'b0);
        rst = 1'b1; arm = 1'b1; clear = 1'b0;
        step();
        expect_out("rst_in_fired", 1'b0, 3'd0, 1'b0);
        rst = 1'b0; arm = 1'b0;
        pulse_arm();
        feed(128'h1);  check("rst_fullmask", 32'(stage), 32'd0);
        feed('0);      check("rst_pat0", 32'(stage), 32'd1);
        repeat (5) step();
        check("rst_tmo_off", 32'(stage), 32'd1);
        feed('0);      check("rst_pat1", 32'(stage), 32'd2);
        feed('0);      check("rst_pat2", 32'(stage), 32'd3);
        feed('0);      expect_out("rst_fire", 1'b1, 3'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
